// File: rtl/uart_state_demux.sv
// Rebuilds the five-word game-state frame from UART words, validates it in shadow
// registers and commits everything to the outputs in one edge; also tracks link health.
module uart_state_demux #(
  parameter int unsigned WORD_TIMEOUT = 65000,
  parameter int unsigned LINK_TIMEOUT = 6500000,
  parameter int unsigned X_MAX        = 1023,
  parameter int unsigned Y_MAX        = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [11:0] pl_posx,
  output logic [11:0] pl_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        frame_valid,
  output logic        link_up,
  output logic [7:0]  err_cnt
);
  localparam int GW = $clog2(WORD_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);

  // State encoding is chosen so that state + 1 equals the tag expected next.
  typedef enum logic [2:0] {W1, W2, W3, W4, W5} state_t;

  state_t        state_q;
  logic [11:0]   sh_plx_q, sh_ply_q, sh_bx_q, sh_by_q;
  logic [9:0]    sh_misc_q;
  logic          commit_q;
  logic [GW-1:0] gap_q;
  logic [LW-1:0] link_cnt_q;

  logic [3:0]  tag, exp_tag;
  logic [11:0] payload;
  logic        x_ok, y_ok, range_ok, word_ok, restart, timeout, error;
  logic [7:0]  err_cnt_d;

  always_comb begin
    tag      = data_in[15:12];
    payload  = data_in[11:0];
    exp_tag  = {1'b0, state_q} + 4'd1;
    x_ok     = ({20'd0, payload} <= X_MAX);
    y_ok     = ({20'd0, payload} <= Y_MAX);
    case (tag)
      4'h1, 4'h3: range_ok = x_ok;
      4'h2, 4'h4: range_ok = y_ok;
      default:    range_ok = 1'b1;
    endcase
    word_ok  = data_valid && (tag == exp_tag) && range_ok;
    restart  = data_valid && (tag == 4'h1) && x_ok;
    timeout  = !data_valid && (state_q != W1) && (gap_q == GW'(WORD_TIMEOUT - 1));
    // Stray non-start words while idle are line noise, not frame errors.
    error    = (data_valid && !word_ok && ((state_q != W1) || (tag == 4'h1))) || timeout;
    err_cnt_d = (error && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= W1;
      sh_plx_q    <= '0;
      sh_ply_q    <= '0;
      sh_bx_q     <= '0;
      sh_by_q     <= '0;
      sh_misc_q   <= '0;
      commit_q    <= 1'b0;
      gap_q       <= '0;
      link_cnt_q  <= '0;
      pl_posx     <= '0;
      pl_posy     <= '0;
      ball_posx   <= '0;
      ball_posy   <= '0;
      pl1_score   <= '0;
      pl2_score   <= '0;
      flag_point  <= 1'b0;
      end_game    <= 1'b0;
      frame_valid <= 1'b0;
      link_up     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      commit_q    <= 1'b0;
      err_cnt     <= err_cnt_d;

      if (commit_q) begin
        pl_posx     <= sh_plx_q;
        pl_posy     <= sh_ply_q;
        ball_posx   <= sh_bx_q;
        ball_posy   <= sh_by_q;
        pl1_score   <= sh_misc_q[3:0];
        pl2_score   <= sh_misc_q[7:4];
        flag_point  <= sh_misc_q[8];
        end_game    <= sh_misc_q[9];
        frame_valid <= 1'b1;
        link_up     <= 1'b1;
        link_cnt_q  <= '0;
      end else begin
        if (link_cnt_q < LW'(LINK_TIMEOUT))
          link_cnt_q <= link_cnt_q + 1'b1;
        if (link_cnt_q >= LW'(LINK_TIMEOUT - 1))
          link_up <= 1'b0;
      end

      if (data_valid || timeout || (state_q == W1))
        gap_q <= '0;
      else
        gap_q <= gap_q + 1'b1;

      if (word_ok) begin
        case (state_q)
          W1: begin sh_plx_q <= payload; state_q <= W2; end
          W2: begin sh_ply_q <= payload; state_q <= W3; end
          W3: begin sh_bx_q  <= payload; state_q <= W4; end
          W4: begin sh_by_q  <= payload; state_q <= W5; end
          W5: begin sh_misc_q <= payload[9:0]; commit_q <= 1'b1; state_q <= W1; end
          default: state_q <= W1;
        endcase
      end else if (error) begin
        if (restart) begin
          sh_plx_q <= payload;
          state_q  <= W2;
        end else begin
          state_q  <= W1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_state_demux.sv
// Directed bench for uart_state_demux with shortened timeouts so every case fits
// in a few thousand cycles; expected values are hand-computed constants.
module tb_uart_state_demux;
  localparam int unsigned WT = 40;
  localparam int unsigned LT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [11:0] pl_posx, pl_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, frame_valid, link_up;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_count = 0;
  int fv_base;

  uart_state_demux #(.WORD_TIMEOUT(WT), .LINK_TIMEOUT(LT), .X_MAX(1023), .Y_MAX(767)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .pl_posx(pl_posx), .pl_posy(pl_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point),
    .end_game(end_game), .frame_valid(frame_valid), .link_up(link_up), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c, input logic [11:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic fp, input logic eg);
    return {6'd0, a, b, c, d, s1, s2, fp, eg};
  endfunction

  function automatic logic [63:0] outs();
    return pack(pl_posx, pl_posy, ball_posx, ball_posy, pl1_score, pl2_score, flag_point, end_game);
  endfunction

  // Callers are always positioned just after a falling edge.
  task automatic send(input logic [15:0] w);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    $display("word 0x%04h sent, err_cnt=%0d", w, err_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] f2;
    logic [63:0] f4;
    f2 = pack(12'h030, 12'h040, 12'h001, 12'h002, 4'd0, 4'd0, 1'b0, 1'b0);
    f4 = pack(12'h001, 12'h002, 12'h003, 12'h004, 4'd0, 4'd0, 1'b0, 1'b0);

    idle(3);
    check_eq("reset_outs", outs(), 64'd0);
    check_eq("reset_err", 64'(err_cnt), 64'd0);
    check_eq("reset_link", 64'(link_up), 64'd0);
    rst = 1'b1;
    idle(1);

    // Basic frame with 10-cycle gaps
    fv_base = fv_count;
    send(16'h1100); idle(10);
    send(16'h2200); idle(10);
    send(16'h3050); idle(10);
    send(16'h4060); idle(10);
    send(16'h5321);
    check_eq("t1_latency_fv", 64'(frame_valid), 64'd0);
    check_eq("t1_latency_outs", outs(), 64'd0);
    idle(1);
    check_eq("t1_fv", 64'(frame_valid), 64'd1);
    check_eq("t1_outs", outs(), pack(12'h100, 12'h200, 12'h050, 12'h060, 4'd1, 4'd2, 1'b1, 1'b1));
    check_eq("t1_link", 64'(link_up), 64'd1);
    check_eq("t1_err", 64'(err_cnt), 64'd0);
    idle(1);
    check_eq("t1_fv_width", 64'(frame_valid), 64'd0);
    check_eq("t1_fv_count", 64'(fv_count - fv_base), 64'd1);

    // Restart mid-frame, back-to-back words
    fv_base = fv_count;
    send(16'h1010); send(16'h2020); send(16'h1030); send(16'h2040);
    send(16'h3001); send(16'h4002); send(16'h5000);
    idle(1);
    check_eq("t2_fv", 64'(frame_valid), 64'd1);
    check_eq("t2_outs", outs(), f2);
    check_eq("t2_err", 64'(err_cnt), 64'd1);
    idle(3);
    check_eq("t2_fv_count", 64'(fv_count - fv_base), 64'd1);

    // Range errors and ignored stray tag
    send(16'h1400); idle(1);
    check_eq("t3_x_err", 64'(err_cnt), 64'd2);
    check_eq("t3_x_state", 64'(dut.state_q), 64'd0);
    check_eq("t3_x_outs", outs(), f2);
    send(16'h1005); send(16'h2300); idle(1);
    check_eq("t3_y_err", 64'(err_cnt), 64'd3);
    check_eq("t3_y_state", 64'(dut.state_q), 64'd0);
    send(16'h3005); idle(1);
    check_eq("t3_stray_err", 64'(err_cnt), 64'd3);
    check_eq("t3_stray_state", 64'(dut.state_q), 64'd0);

    // Word timeout, then the word-wins case
    send(16'h1001);
    idle(WT - 1);
    check_eq("t4_pre_timeout_err", 64'(err_cnt), 64'd3);
    idle(1);
    check_eq("t4_timeout_err", 64'(err_cnt), 64'd4);
    check_eq("t4_timeout_state", 64'(dut.state_q), 64'd0);
    send(16'h1001);
    idle(WT - 1);
    send(16'h2002);
    check_eq("t4_win_err", 64'(err_cnt), 64'd4);
    check_eq("t4_win_state", 64'(dut.state_q), 64'd2);
    send(16'h3003); send(16'h4004); send(16'h5000);
    idle(1);
    check_eq("t4_commit_outs", outs(), f4);
    check_eq("t4_commit_link", 64'(link_up), 64'd1);

    // Link timeout
    idle(LT - 1);
    check_eq("t5_link_hold", 64'(link_up), 64'd1);
    idle(1);
    check_eq("t5_link_drop", 64'(link_up), 64'd0);
    check_eq("t5_outs_hold", outs(), f4);

    // Reset mid-frame
    send(16'h1111); send(16'h2222); send(16'h3333);
    rst = 1'b0;
    idle(1);
    check_eq("t6_rst_outs", outs(), 64'd0);
    check_eq("t6_rst_err", 64'(err_cnt), 64'd0);
    check_eq("t6_rst_link", 64'(link_up), 64'd0);
    rst = 1'b1;
    idle(1);
    fv_base = fv_count;
    send(16'h4044); send(16'h5001);
    send(16'h13FF); send(16'h2100); send(16'h3200); send(16'h42FF); send(16'h5000);
    idle(1);
    check_eq("t6_outs", outs(), pack(12'h3FF, 12'h100, 12'h200, 12'h2FF, 4'd0, 4'd0, 1'b0, 1'b0));
    check_eq("t6_err", 64'(err_cnt), 64'd0);
    idle(2);
    check_eq("t6_fv_count", 64'(fv_count - fv_base), 64'd1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(16'h1400);
    idle(1);
    check_eq("t7_err_sat", 64'(err_cnt), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
